// File: rtl/rv_pkg.sv
// Shared RISC-V core types and constants.
// Used by the fetch stage and its buffer.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT =
    32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries.
// Reset and flush both return it to empty.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wr_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited
// imem requests, response buffer and redirect flush.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] tgt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;

  assign tgt  = {redirect_pc[XLEN-1:2], 2'b00};
  assign used = {1'b0, outstanding}
              + {1'b0, fifo_count};

  assign imem_req_valid = !reset
                       && !redirect_valid
                       && (used < LIMIT);
  assign imem_req_addr  = pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  // A beat with nothing outstanding is stray.
  assign rsp_take = imem_rsp_valid
                 && (outstanding != '0);
  assign push = rsp_take
             && (discard == '0)
             && !redirect_valid;

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst       = fifo_empty ? '0 : head.inst;
  assign inst_pc    = fifo_empty ? '0 : head.pc;

  assign wr_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // PC, response PC, in-flight and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      pc          <= tgt;
      rsp_pc      <= tgt;
      outstanding <= outstanding - CW'(rsp_take);
      discard     <= outstanding - CW'(rsp_take);
    end else begin
      if (req_fire)
        pc <= pc + XLEN'(INST_BYTES);
      outstanding <= outstanding
                   + CW'(req_fire)
                   - CW'(rsp_take);
      if (rsp_take) begin
        if (discard != '0)
          discard <= discard - CW'(1);
        else
          rsp_pc <= rsp_pc + XLEN'(INST_BYTES);
      end
    end
  end

  // Credits guarantee a push never meets a full buffer.
  always @(posedge clk) begin
    if (!reset)
      assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Memory model plus PC-stream reference checker.
`timescale 1ns/1ps
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(
    input logic [31:0] a
  );
    return ~a ^ 32'h0F0F_0033;
  endfunction

  // Instruction memory: in-order, fixed latency.
  typedef struct {
    logic [31:0] addr;
    int          t;
  } req_t;

  req_t q[$];
  int   cyc = 0;
  int   lat = 1;
  bit   spur = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (q.size() > 0
                 && q[0].t + lat <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(q[0].addr);
      void'(q.pop_front());
    end
  end

  always begin
    @(negedge clk);
    if (reset)
      q.delete();
    else if (imem_req_valid && imem_req_ready)
      q.push_back('{imem_req_addr, cyc});
  end

  // Reference: requests and deliveries are each a
  // +4 stream from the last reset or redirect target.
  logic [31:0] m_req;
  logic [31:0] m_out;
  int n_acc, n_inst, t_acc, t_inst;

  always begin
    @(negedge clk);
    if (reset) begin
      chk("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
      m_req  = RPC;
      m_out  = RPC;
      n_acc  = 0;
      n_inst = 0;
      t_acc  = -1;
      t_inst = -1;
    end else begin
      if (redirect_valid) begin
        chk("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        chk("no_inst_on_redirect", {31'd0, inst_valid}, 32'd0);
      end
      if (imem_req_valid)
        chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, m_req);
        m_req += 32'd4;
        n_acc++;
        if (t_acc < 0) t_acc = cyc;
      end
      if (inst_valid) begin
        if (t_inst < 0) t_inst = cyc;
        chk("inst_pc", inst_pc, m_out);
        chk("inst", inst, word(m_out));
        if (inst_ready) begin
          m_out += 32'd4;
          n_inst++;
        end
      end
      if (redirect_valid) begin
        m_req = {redirect_pc[31:2], 2'b00};
        m_out = m_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    spur           = 1'b0;
    lat            = 1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_inst(input string name,
                           input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    // Streaming with 1-cycle memory.
    do_reset();
    @(negedge clk);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, RPC);
    repeat (15) tick();
    chk("first_latency", t_inst - t_acc, 32'd2);
    chk("stream_min", {31'd0, n_inst >= 8}, 32'd1);

    // Decoder stall fills the buffer.
    do_reset();
    inst_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_accepts", n_acc, 32'd2);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_head_pc", inst_pc, 32'h0);
    tick();
    inst_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("resume_valid", {31'd0, inst_valid}, 32'd1);
    chk("resume_pc", inst_pc, 32'h4);
    repeat (10) tick();

    // Redirect with two stale fetches in flight.
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("lat3_accepts", n_acc, 32'd2);
    wait_inst("lat3_wait", 30);
    chk("lat3_pc", inst_pc, 32'h100);
    chk("lat3_inst", inst, word(32'h100));

    // Redirect coinciding with the only response.
    do_reset();
    lat = 2;
    tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_inst("same_wait", 20);
    chk("same_pc", inst_pc, 32'h40);

    // Misaligned target, wrap, back-to-back redirect.
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("align_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("align_addr", imem_req_addr, 32'h200);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_valid1", {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_addr1", imem_req_addr, 32'h0);
    wait_inst("wrap_wait", 20);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    tick();
    redirect_pc    = 32'h0000_0600;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("b2b_addr", imem_req_addr, 32'h600);
    wait_inst("b2b_wait", 20);
    chk("b2b_pc", inst_pc, 32'h600);

    // Reset with a full buffer.
    do_reset();
    inst_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    chk("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_addr", imem_req_addr, RPC);

    // Reset with two requests outstanding,
    // then a stray response beat.
    inst_ready = 1'b1;
    lat = 6;
    tick();
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    spur = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("spur_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("spur_req_addr", imem_req_addr, RPC);
    tick();
    @(negedge clk);
    chk("spur_ignored", {31'd0, inst_valid}, 32'd0);
    tick();
    lat = 1;
    imem_req_ready = 1'b1;
    wait_inst("spur_wait", 20);
    chk("spur_pc", inst_pc, RPC);
    chk("spur_inst", inst, word(RPC));
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the instruction decoder. It holds the PC and issues word-aligned read requests to instruction memory over a valid/ready request channel. It receives in-order responses and buffers them with their PCs in a small FIFO. It then presents {instruction, pc} to decode over a valid/ready handshake. Branch and jump redirects from execute flush all in-flight and buffered fetches and restart at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 2, FIFO entries; also the maximum number of requests in flight plus buffered (credit limit).

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  32  byte address of the requested word; bits [1:0] are always 0.
imem_req_ready  in  1  memory accepts the request.
imem_rsp_valid  in  1  read data valid (in order, at least 1 cycle after request accept).
imem_rsp_data  in  32  instruction word.
redirect_valid  in  1  flush and restart.
redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
inst_valid  out  1  instruction available for decode.
inst  out  32  instruction word to decoder.
inst_pc  out  32  PC of inst.
inst_ready  in  1  decoder accepts.

Behaviour:
- State:
  - pc: next request address.
  - rsp_pc: PC of the next expected response.
  - outstanding: accepted requests not yet answered, width $clog2(DEPTH+1).
  - discard: responses still to be dropped, same width.
  - FIFO: {pc, inst} entries with a count.
- Reset (synchronous): pc = rsp_pc = RESET_PC; outstanding = discard = 0; FIFO empty. Outputs in the cycle after reset: imem_req_valid = 0 during reset, inst_valid = 0, inst and inst_pc = 0.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (outstanding + fifo_count) < DEPTH.
  - imem_req_addr = pc.
  - On accept (valid & ready): pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0); outstanding increments.
  - Address is stable while valid & !ready, except that a redirect withdraws the request.
- Response handling (imem_rsp_valid):
  - outstanding decrements in every case.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise push {rsp_pc, imem_rsp_data} into the FIFO and advance rsp_pc by 4.
  - imem_rsp_valid while outstanding == 0 is a protocol error; the beat is ignored with no state change.
- Credit rule: the FIFO can never overflow. A push to a full FIFO is impossible by construction; add an assertion for it.
- Output:
  - inst_valid = FIFO non-empty && !redirect_valid; inst and inst_pc come from the FIFO head.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle are both honoured.
  - Data pushed in cycle N is visible at the outputs in cycle N+1 (registered).
  - Best-case latency: request accepted at T, response at T+1, inst_valid at T+2.
- Redirect (cycle R, redirect_valid = 1):
  - Clear the FIFO; no pop occurs in cycle R.
  - pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}.
  - discard <= outstanding - imem_rsp_valid; a response in cycle R is dropped.
  - No request is issued in cycle R; the first new request can be issued at R+1.
  - redirect_valid on consecutive cycles: the last one wins, and each cycle recomputes discard the same way.
- Mid-operation reset: overrides everything, including redirect. Memory must be reset with the same signal; stale responses are covered by the protocol-error rule.
- No misaligned-fetch exception is generated in this block.

Decomposition:
- Shared package rv_pkg:
  - XLEN = 32, INST_BYTES = 4.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
  - RESET_PC default constant.
- Sub-module fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, head, full and empty. It resets and flushes to empty.
- fetch_unit holds the PC/credit/discard logic and instantiates fetch_fifo.

Test Plan:
- Reset, then ready = 1 with 1-cycle memory and inst_ready = 1 -> requests 0x0, 0x4, 0x8, ...; first inst_valid exactly 2 cycles after the first accept with inst_pc = 0x0; sustained throughput of 1 instruction per cycle.
- inst_ready = 0 for 10 cycles -> at most DEPTH = 2 accepts, imem_req_valid drops to 0, FIFO holds pc 0x0 and 0x4; releasing inst_ready resumes with no loss or duplicates.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc = 0x100 -> both stale responses dropped; next inst_pc = 0x100; no request in the redirect cycle.
- Redirect in the same cycle as a response, with outstanding = 1 -> response dropped, discard = 0; next delivered instruction is from the redirect target.
- redirect_pc = 0x0000_0203 -> next request address 0x200; then redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Reset asserted while 2 requests are outstanding and the FIFO is full -> next cycle inst_valid = 0, first request is to RESET_PC, spurious imem_rsp_valid is ignored.
